pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter of the multi-cycle MIPS core and sequences fetch/execute.
//  Issues instruction fetches, holds the fetched instruction (IR) for the datapath, and on
//  completion selects the next PC: sequential, taken branch, J/JAL jump target or JR register.
//  Sits between instruction memory and the datapath/control unit.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  EXC_VECTOR  32'h0000_0180  PC loaded on misaligned JR target
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  imem_req     out  1   fetch request, held until imem_ready
//  imem_addr    out  32  fetch address (= pc)
//  imem_ready   in   1   imem_rdata valid this cycle; completes fetch
//  imem_rdata   in   32  fetched instruction word
//  ir           out  32  latched instruction, stable while ir_valid
//  ir_valid     out  1   high in EXEC state
//  exec_done    in   1   datapath finished IR; pc_sel/branch_taken/rs_value valid this cycle
//  pc_sel       in   2   0 SEQ, 1 BRANCH, 2 JUMP, 3 JR
//  branch_taken in   1   condition result, used only when pc_sel==BRANCH
//  rs_value     in   32  register operand, used only when pc_sel==JR
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (link value for JAL), combinational from pc
//  exc          out  1   one-cycle pulse: misaligned JR redirected to EXC_VECTOR
// BEHAVIOUR
//  - Reset (sync, high): pc<=RESET_PC, state<=FETCH, ir<=0, exc<=0; imem_req=0, ir_valid=0
//    while rst high. Reset mid-fetch/mid-exec aborts; no PC update from that cycle.
//  - FSM, 2 states:
//    FETCH: imem_req=1, imem_addr=pc. On imem_ready: ir<=imem_rdata, ->EXEC.
//           exec_done ignored.
//    EXEC : ir_valid=1, imem_req=0. On exec_done: pc<=next_pc, ->FETCH. imem_ready ignored.
//  - Fetch of new PC asserts the cycle after exec_done (min 2 cycles/instruction when
//    imem_ready same-cycle as request).
//  - next_pc (32-bit, modulo 2^32, wrap silently: 32'hFFFF_FFFC+4 = 0):
//    SEQ    : pc+4
//    BRANCH : taken ? pc+4 + {{14{ir[15]}}, ir[15:0], 2'b00} : pc+4
//    JUMP   : {pc_plus4[31:28], ir[25:0], 2'b00}
//    JR     : rs_value if rs_value[1:0]==0; else EXC_VECTOR and exc=1 for one cycle
//  - exc asserts in the cycle after exec_done (registered), otherwise 0.
//  - No branch delay slot. pc only changes on exec_done in EXEC or reset.
// STRUCTURE
//  - Package mips_pc_pkg: PC_SEL_SEQ/BRANCH/JUMP/JR (2-bit), state encoding
//    ST_FETCH/ST_EXEC, default RESET_PC and EXEC_VECTOR constants.
//  - Sub-module jump_target_gen: combinational {pc_plus4[31:28], index26, 2'b00};
//    instantiated once for JUMP. Branch adder and mux stay inline.
// TESTING
//  1 Reset: rst 3 cycles -> pc=0, imem_req=0, ir_valid=0; first cycle after: imem_req=1, addr=0.
//  2 Sequential: imem_ready delayed 2 cycles, exec_done with SEQ at pc=0x100 -> pc=0x104,
//    imem_req high next cycle, ir held stable through wait cycles.
//  3 Branch: pc=0x200, ir[15:0]=16'hFFFE, taken -> pc=0x1FC; not taken -> pc=0x204.
//  4 Jump: pc=0x3FFF_FFFC, ir[25:0]=26'h0000040 -> pc=0x4000_0100 (uses pc+4 upper bits).
//  5 JR: rs_value=0x0040_0010 -> pc=0x0040_0010, exc=0; rs_value=0x0040_0012 -> pc=0x180, exc pulse 1 cycle.
//  6 Spurious/abort: exec_done in FETCH and imem_ready in EXEC ignored; rst during EXEC -> pc=RESET_PC.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared PC-select codes, sequencer state encoding and default vectors.
package mips_pc_pkg;
    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_JR     = 2'd3
    } pc_sel_e;
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake plus datapath control/observation signals.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        exec_done;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exc;
    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, exc,
        input  imem_ready, imem_rdata, exec_done, pc_sel, branch_taken, rs_value
    );
    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, exc,
        output imem_ready, imem_rdata, exec_done, pc_sel, branch_taken, rs_value
    );
endinterface

// File: rtl/jump_target_gen.sv
// jump_target_gen: J/JAL target from the upper nibble of pc+4 and the 26-bit word index.
module jump_target_gen (
    input  logic [3:0]  pc_hi_i,
    input  logic [25:0] index_i,
    output logic [31:0] target_o
);
    assign target_o = {pc_hi_i, index_i, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches into IR, and selects the next PC when the datapath completes.
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic        exc_q, exc_d;
    logic [31:0] pc_plus4, jump_target, branch_target, next_pc;
    logic        jr_bad;

    jump_target_gen u_jump_target_gen (
        .pc_hi_i  (pc_plus4[31:28]),
        .index_i  (ir_q[25:0]),
        .target_o (jump_target)
    );

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign jr_bad        = bus.rs_value[1:0] != 2'b00;
    assign next_pc = bus.pc_sel == PC_SEL_SEQ    ? pc_plus4 :
                     bus.pc_sel == PC_SEL_BRANCH ? (bus.branch_taken ? branch_target : pc_plus4) :
                     bus.pc_sel == PC_SEL_JUMP   ? jump_target :
                     jr_bad ? EXC_VECTOR : bus.rs_value;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        exc_d   = 1'b0;
        if (state_q == ST_FETCH) begin
            if (bus.imem_ready) begin
                ir_d    = bus.imem_rdata;
                state_d = ST_EXEC;
            end
        end else if (bus.exec_done) begin
            pc_d    = next_pc;
            exc_d   = bus.pc_sel == PC_SEL_JR && jr_bad;
            state_d = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            exc_q   <= exc_d;
        end
    end

    // Handshake outputs are forced low combinationally for the whole reset window.
    assign bus.imem_req  = !rst && state_q == ST_FETCH;
    assign bus.ir_valid  = !rst && state_q == ST_EXEC;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.ir        = ir_q;
    assign bus.exc       = exc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios checked every cycle against a transaction-level PC model.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ir = 32'd0;
    logic        m_exec = 1'b0;
    logic        m_exc = 1'b0;
    logic        started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Next PC straight from the ISA rules: {exception flag, new pc}.
    function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                               input logic [31:0] rs, input logic [1:0] sel,
                                               input logic tk);
        logic [31:0] p4;
        int          off;
        p4  = pc + 32'd4;
        off = int'($signed(ir[15:0])) * 4;
        case (sel)
            2'd0:    return {1'b0, p4};
            2'd1:    return {1'b0, tk ? p4 + 32'(off) : p4};
            2'd2:    return {1'b0, (p4 & 32'hF000_0000) | (32'(ir[25:0]) << 2)};
            default: return (rs % 4 == 0) ? {1'b0, rs} : {1'b1, 32'h0000_0180};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [32:0] n;
        started = 1'b1;
        if (rst) begin
            m_pc = 32'd0; m_ir = 32'd0; m_exec = 1'b0; m_exc = 1'b0;
        end else begin
            m_exc = 1'b0;
            if (!m_exec && bus.imem_ready) begin
                m_ir   = bus.imem_rdata;
                m_exec = 1'b1;
            end else if (m_exec && bus.exec_done) begin
                n      = model_next(m_pc, m_ir, bus.rs_value, bus.pc_sel, bus.branch_taken);
                m_pc   = n[31:0];
                m_exc  = n[32];
                m_exec = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", 32'(bus.imem_req), 32'(!rst && !m_exec));
            chk("ir_valid", 32'(bus.ir_valid), 32'(!rst && m_exec));
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("pc", bus.pc, m_pc);
            chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("exc", 32'(bus.exc), 32'(m_exc));
            if (m_exec && !rst) chk("ir", bus.ir, m_ir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] instr, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) tick();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = instr;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0BAD_F00D;
    endtask

    task automatic exec(input logic [1:0] sel, input logic tk, input logic [31:0] rs, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) tick();
        bus.exec_done    = 1'b1;
        bus.pc_sel       = sel;
        bus.branch_taken = tk;
        bus.rs_value     = rs;
        tick();
        bus.exec_done    = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic goto(input logic [31:0] target);
        fetch(32'h0000_0008, 0);
        exec(2'd3, 1'b0, target, 0);
    endtask

    task automatic expect_pc(input string name, input logic [31:0] lit);
        @(negedge clk);
        chk(name, bus.pc, lit);
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0; bus.exec_done = 1'b0;
        bus.pc_sel = 2'd0; bus.branch_taken = 1'b0; bus.rs_value = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir", bus.ir, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'd0);
        goto(32'h0000_0100);
        expect_pc("jr_to_100", 32'h0000_0100);
        fetch(32'hDEAD_BEEF, 2);
        exec(2'd0, 1'b0, 32'd0, 2);
        expect_pc("seq", 32'h0000_0104);
        chk("seq_req", 32'(bus.imem_req), 32'd1);
        chk("seq_ir_held", bus.ir, 32'hDEAD_BEEF);
        goto(32'h0000_0200);
        fetch(32'h1000_FFFE, 0);
        exec(2'd1, 1'b1, 32'd0, 1);
        expect_pc("br_taken", 32'h0000_01FC);
        goto(32'h0000_0200);
        fetch(32'h1000_FFFE, 1);
        exec(2'd1, 1'b0, 32'd0, 0);
        expect_pc("br_not_taken", 32'h0000_0204);
        goto(32'h3FFF_FFFC);
        fetch(32'h0800_0040, 0);
        exec(2'd2, 1'b0, 32'd0, 0);
        expect_pc("jump", 32'h4000_0100);
        goto(32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0);
        exec(2'd0, 1'b0, 32'd0, 0);
        expect_pc("seq_wrap", 32'h0000_0000);
        goto(32'h0040_0010);
        expect_pc("jr_ok", 32'h0040_0010);
        chk("jr_ok_exc", 32'(bus.exc), 32'd0);
        fetch(32'h0000_0008, 0);
        exec(2'd3, 1'b0, 32'h0040_0012, 0);
        expect_pc("jr_bad", 32'h0000_0180);
        chk("jr_bad_exc", 32'(bus.exc), 32'd1);
        @(negedge clk);
        chk("jr_bad_exc_clear", 32'(bus.exc), 32'd0);
        tick();
        bus.exec_done = 1'b1;
        bus.pc_sel = 2'd3;
        bus.rs_value = 32'h0000_4000;
        repeat (2) tick();
        bus.exec_done = 1'b0;
        expect_pc("spurious_done", 32'h0000_0180);
        fetch(32'h1234_5678, 0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFF_0000;
        repeat (2) tick();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        chk("spurious_ready_ir", bus.ir, 32'h1234_5678);
        tick();
        rst = 1'b1;
        bus.exec_done = 1'b1;
        bus.pc_sel = 2'd0;
        tick();
        bus.exec_done = 1'b0;
        rst = 1'b0;
        expect_pc("rst_in_exec", 32'h0000_0000);
        chk("rst_in_exec_req", 32'(bus.imem_req), 32'd1);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
